mips_control_fsm: RTL
=====================

Name: mips_control_fsm

Overview:
- Multi-cycle instruction decoder/control FSM; the driving end of the PC unit's control interface.
- Accepts an instruction word from instruction memory, latches it, and sequences FETCH/DECODE/EXEC/MEM/WB.
- Produces branchAddr, jumpAddr, ctrlBEQ/ctrlBNE/ctrlJ/ctrlJR and a one-cycle pc_en per retired instruction.
- Also drives regfile, ALU and data-memory controls.

Parameters:
- JAL_REG, 31, register index written by JAL.
- WAIT_MAX, 255, FETCH cycles without instr_valid before fetch_timeout pulses (8-bit counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- instr  in  32  instruction word from instruction memory
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  FSM in FETCH, will latch instr
- ALUzero  in  1  ALU zero flag
- branchAddr  out  16  IR[15:0]
- jumpAddr  out  26  IR[25:0]
- ctrlBEQ, ctrlBNE, ctrlJ, ctrlJR  out  1 each  PC-unit selects, asserted only with pc_en
- pc_en  out  1  PC register load strobe
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- alu_op  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- alu_src_imm  out  1  ALU B = immediate
- imm_zext  out  1  zero-extend immediate (XORI), else sign-extend
- reg_we  out  1  regfile write strobe
- reg_dst  out  2  00 rt, 01 rd, 10 JAL_REG
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
- mem_re, mem_we  out  1 each  data memory read/write
- fetch_timeout  out  1  one-cycle pulse
- halted  out  1  illegal-instruction halt (feature only)

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low.
- Reset: state=FETCH, IR=0, wait counter=0. All strobes (pc_en, reg_we, mem_we, mem_re, ctrl*, fetch_timeout, halted) are 0.
- instr_ready = (state==FETCH); it is 1 immediately after reset.
- FETCH: on instr_valid, latch IR and go to DECODE; otherwise stay in FETCH and increment the wait counter.
  - When the counter reaches WAIT_MAX: pulse fetch_timeout for one cycle, clear the counter, remain in FETCH.
- DECODE, by opcode IR[31:26]:
  - 0x02 J: pc_en=1, ctrlJ=1, then FETCH.
  - 0x03 JAL: go to WB.
  - 0x00 with funct 0x08 (JR): pc_en=1, ctrlJR=1, ctrlJ=1, then FETCH.
  - All other legal opcodes: go to EXEC.
- EXEC:
  - BEQ (0x04) / BNE (0x05): alu_op=SUB, alu_src_imm=0. Same cycle: pc_en=1, ctrlBEQ or ctrlBNE=1, with ALUzero sampled combinationally. Then FETCH.
  - LW (0x23) / SW (0x2B): alu_op=ADD, alu_src_imm=1, sign-extended immediate. Go to MEM.
  - ADDI (0x08): ADD, imm sign-extended. XORI (0x0E): XOR, imm_zext=1. R-type funct 0x20/0x22/0x2A: ADD/SUB/SLT. All go to WB.
- MEM:
  - LW: mem_re=1, go to WB.
  - SW: mem_we=1, pc_en=1, then FETCH.
- WB: reg_we=1 and pc_en=1, then FETCH.
  - reg_dst/wb_sel: R-type 01/00; ADDI/XORI 00/00; LW 00/01; JAL 10/10 with ctrlJ=1.
- ALU controls stay stable from EXEC through WB. They derive from IR, not instr.
- Exactly one pc_en pulse per instruction. Latency from accept (FETCH cycle with instr_valid) to pc_en:
  - J/JR: 1
  - BEQ/BNE/JAL: 2
  - R-type/ADDI/XORI/SW: 3
  - LW: 4
- Illegal opcode/funct: treated as NOP, going DECODE→FETCH with pc_en=1 and no ctrl*.
- rst_n low mid-instruction: abort immediately, with no further strobes and no partial writeback.
- instr/instr_valid are ignored outside FETCH.

Optional Feature:
- Macro: MIPS_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode/funct in DECODE enters the HALT state. halted=1, pc_en and all strobes stay 0, and instr_ready=0 until reset.
- Undefined: NOP behaviour as above, and halted is tied 0.

Test Plan:
- Reset, then instr=0x00432020 (add $4,$2,$3) with instr_valid → pc_en exactly 3 cycles after accept. reg_we=1, reg_dst=01, rd=4, alu_op=000 in that cycle; ctrl* all 0.
- instr=0x10220003 (beq $1,$2,3) with ALUzero=1 → after 2 cycles pc_en=1, ctrlBEQ=1, branchAddr=0x0003. Repeat as BNE (0x14220003) with ALUzero=1 → ctrlBNE=1 with pc_en.
- instr=0x0C000010 (jal) → 2 cycles later pc_en=1, ctrlJ=1, reg_we=1, reg_dst=10, wb_sel=10, jumpAddr=0x0000010.
- instr=0x8C450004 (lw $5,4($2)) → EXEC alu_src_imm=1; MEM mem_re=1; WB wb_sel=01, reg_we=1, pc_en 4 cycles after accept. Pulse rst_n low during MEM in a second run → no reg_we/pc_en, instr_ready=1.
- Hold instr_valid=0 for 256 cycles → fetch_timeout pulses once at cycle 255, with no pc_en.
- Opcode 0x3F: macro off → pc_en 1 cycle after accept, then instr_ready=1. Macro on → halted=1 and instr_ready=0 held for 20 cycles, cleared by rst_n.

Source files
------------

// File: rtl/mips_control_fsm_if.sv
// Control interface between the multi-cycle control FSM (master) and the
// instruction memory / PC unit / datapath side (slave).
interface mips_control_fsm_if;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;

    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               ALUzero;
    logic [15:0]        branchAddr;
    logic [25:0]        jumpAddr;
    logic               ctrlBEQ;
    logic               ctrlBNE;
    logic               ctrlJ;
    logic               ctrlJR;
    logic               pc_en;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [2:0]         alu_op;
    logic               alu_src_imm;
    logic               imm_zext;
    logic               reg_we;
    logic [1:0]         reg_dst;
    logic [1:0]         wb_sel;
    logic               mem_re;
    logic               mem_we;
    logic               fetch_timeout;
    logic               halted;

    modport master (
        input  instr, instr_valid, ALUzero,
        output instr_ready, branchAddr, jumpAddr,
               ctrlBEQ, ctrlBNE, ctrlJ, ctrlJR, pc_en,
               rs, rt, rd, alu_op, alu_src_imm, imm_zext,
               reg_we, reg_dst, wb_sel, mem_re, mem_we,
               fetch_timeout, halted
    );

    modport slave (
        output instr, instr_valid, ALUzero,
        input  instr_ready, branchAddr, jumpAddr,
               ctrlBEQ, ctrlBNE, ctrlJ, ctrlJR, pc_en,
               rs, rt, rd, alu_op, alu_src_imm, imm_zext,
               reg_we, reg_dst, wb_sel, mem_re, mem_we,
               fetch_timeout, halted
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with one
// pc_en strobe per retired instruction. All control outputs are registered:
// they are computed from the next state and the next IR value so that each
// strobe is high exactly during the state it belongs to.
// Optional feature macro MIPS_ILLEGAL_TRAP_EN: an illegal instruction halts
// the FSM (halted=1) until reset; otherwise it retires as a NOP.
module mips_control_fsm #(
    parameter int unsigned JAL_REG  = 31,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_control_fsm_if.master    bus
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

`ifdef MIPS_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_ILL, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_LW, K_SW,
        K_ADDI, K_XORI, K_ADD, K_SUB, K_SLT
    } kind_t;

    // Instruction class from opcode/funct.
    function automatic kind_t classify(input logic [INSTR_W-1:0] w);
        kind_t k;
        k = K_ILL;
        case (w[31:26])
            OP_RTYPE: begin
                case (w[5:0])
                    FN_JR:   k = K_JR;
                    FN_ADD:  k = K_ADD;
                    FN_SUB:  k = K_SUB;
                    FN_SLT:  k = K_SLT;
                    default: k = K_ILL;
                endcase
            end
            OP_J:    k = K_J;
            OP_JAL:  k = K_JAL;
            OP_BEQ:  k = K_BEQ;
            OP_BNE:  k = K_BNE;
            OP_ADDI: k = K_ADDI;
            OP_XORI: k = K_XORI;
            OP_LW:   k = K_LW;
            OP_SW:   k = K_SW;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    state_t               state, state_nx;
    logic [INSTR_W-1:0]   ir, ir_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    kind_t                kind_nx;
    logic                 tmo_nx;

    logic instr_ready_q, pc_en_q, beq_q, bne_q, j_q, jr_q;
    logic reg_we_q, mem_re_q, mem_we_q, tmo_q;
    logic alu_src_imm_q, imm_zext_q;
    logic [2:0] alu_op_q;
    logic [1:0] reg_dst_q, wb_sel_q;

    // Next state, next IR and FETCH wait counter.
    always_comb begin
        ir_nx    = ir;
        state_nx = state;
        cnt_nx   = cnt;
        tmo_nx   = 1'b0;
        if (state == ST_FETCH && bus.instr_valid) begin
            ir_nx = bus.instr;
        end
        kind_nx = classify(ir_nx);
        case (state)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    state_nx = ST_DECODE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    tmo_nx = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                case (kind_nx)
                    K_J, K_JR: state_nx = ST_FETCH;
                    K_JAL:     state_nx = ST_WB;
                    K_ILL:     state_nx = TRAP_EN ? ST_HALT : ST_FETCH;
                    default:   state_nx = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (kind_nx)
                    K_BEQ, K_BNE: state_nx = ST_FETCH;
                    K_LW, K_SW:   state_nx = ST_MEM;
                    default:      state_nx = ST_WB;
                endcase
            end
            ST_MEM:  state_nx = (kind_nx == K_LW) ? ST_WB : ST_FETCH;
            ST_WB:   state_nx = ST_FETCH;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_FETCH;
        endcase
    end

    // State, IR and registered control outputs for the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FETCH;
            ir            <= '0;
            cnt           <= '0;
            instr_ready_q <= 1'b1;
            pc_en_q       <= 1'b0;
            beq_q         <= 1'b0;
            bne_q         <= 1'b0;
            j_q           <= 1'b0;
            jr_q          <= 1'b0;
            reg_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            tmo_q         <= 1'b0;
            alu_op_q      <= ALU_ADD;
            alu_src_imm_q <= 1'b0;
            imm_zext_q    <= 1'b0;
            reg_dst_q     <= 2'b00;
            wb_sel_q      <= 2'b00;
        end else begin
            state         <= state_nx;
            ir            <= ir_nx;
            cnt           <= cnt_nx;
            instr_ready_q <= (state_nx == ST_FETCH);
            tmo_q         <= tmo_nx;
            pc_en_q       <= (state_nx == ST_DECODE &&
                              (kind_nx == K_J || kind_nx == K_JR ||
                               (kind_nx == K_ILL && !TRAP_EN))) ||
                             (state_nx == ST_EXEC &&
                              (kind_nx == K_BEQ || kind_nx == K_BNE)) ||
                             (state_nx == ST_MEM && kind_nx == K_SW) ||
                             (state_nx == ST_WB);
            beq_q         <= (state_nx == ST_EXEC && kind_nx == K_BEQ);
            bne_q         <= (state_nx == ST_EXEC && kind_nx == K_BNE);
            j_q           <= (state_nx == ST_DECODE &&
                              (kind_nx == K_J || kind_nx == K_JR)) ||
                             (state_nx == ST_WB && kind_nx == K_JAL);
            jr_q          <= (state_nx == ST_DECODE && kind_nx == K_JR);
            reg_we_q      <= (state_nx == ST_WB);
            mem_re_q      <= (state_nx == ST_MEM && kind_nx == K_LW);
            mem_we_q      <= (state_nx == ST_MEM && kind_nx == K_SW);
            case (kind_nx)
                K_BEQ, K_BNE, K_SUB: alu_op_q <= ALU_SUB;
                K_XORI:              alu_op_q <= ALU_XOR;
                K_SLT:               alu_op_q <= ALU_SLT;
                default:             alu_op_q <= ALU_ADD;
            endcase
            alu_src_imm_q <= (kind_nx == K_LW || kind_nx == K_SW ||
                              kind_nx == K_ADDI || kind_nx == K_XORI);
            imm_zext_q    <= (kind_nx == K_XORI);
            case (kind_nx)
                K_ADD, K_SUB, K_SLT: begin reg_dst_q <= 2'b01; wb_sel_q <= 2'b00; end
                K_LW:                begin reg_dst_q <= 2'b00; wb_sel_q <= 2'b01; end
                K_JAL:               begin reg_dst_q <= 2'b10; wb_sel_q <= 2'b10; end
                default:             begin reg_dst_q <= 2'b00; wb_sel_q <= 2'b00; end
            endcase
        end
    end

`ifdef MIPS_ILLEGAL_TRAP_EN
    logic halted_q;

    // Sticky halt indication, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_nx == ST_HALT);
        end
    end

    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.instr_ready   = instr_ready_q;
    assign bus.branchAddr    = ir[15:0];
    assign bus.jumpAddr      = ir[25:0];
    assign bus.rs            = ir[25:21];
    assign bus.rt            = ir[20:16];
    assign bus.rd            = ir[15:11];
    assign bus.pc_en         = pc_en_q;
    assign bus.ctrlBEQ       = beq_q;
    assign bus.ctrlBNE       = bne_q;
    assign bus.ctrlJ         = j_q;
    assign bus.ctrlJR        = jr_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_src_imm   = alu_src_imm_q;
    assign bus.imm_zext      = imm_zext_q;
    assign bus.reg_we        = reg_we_q;
    assign bus.reg_dst       = reg_dst_q;
    assign bus.wb_sel        = wb_sel_q;
    assign bus.mem_re        = mem_re_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.fetch_timeout = tmo_q;
endmodule
